// File: rtl/systolic_array_mac_pe.sv
// Output-stationary systolic-array PE: forwards x/y operands, accumulates signed
// x*y products in MAC mode, and joins a per-column result shift chain on drain.
module systolic_array_mac_pe #(
  parameter int data_width = 32,
  parameter int acc_width  = 72,
  parameter int x_delay    = 2,
  parameter int n_upstream = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mode,
  input  logic                  clear,
  input  logic                  drain,
  input  logic [data_width-1:0] x_in,
  input  logic                  x_val_in,
  input  logic [data_width-1:0] y_in,
  input  logic                  y_val_in,
  input  logic [acc_width-1:0]  res_in,
  input  logic                  res_val_in,
  output logic [data_width-1:0] x_out,
  output logic                  x_val_out,
  output logic [data_width-1:0] y_out,
  output logic                  y_val_out,
  output logic [acc_width-1:0]  res_out,
  output logic                  res_val_out,
  output logic                  busy
);

  localparam int CW = (n_upstream > 0) ? $clog2(n_upstream + 1) : 1;
  localparam logic [CW-1:0] N_UP = CW'(n_upstream);

  typedef enum logic {S_ACC, S_DRAIN} state_t;

  logic [x_delay-1:0][data_width-1:0] r_x;
  logic [x_delay-1:0]                 r_xv;
  logic [data_width-1:0]              r_y;
  logic                               r_yv;
  logic [acc_width-1:0]               r_acc;
  logic [acc_width-1:0]               r_res;
  logic                               r_res_val;
  logic [CW-1:0]                      r_cnt;
  state_t                             r_state;

  logic                               w_pair;
  logic signed [2*data_width-1:0]     w_xe;
  logic signed [2*data_width-1:0]     w_ye;
  logic signed [2*data_width-1:0]     w_prod;
  logic [acc_width-1:0]               w_prod_ext;
  logic [acc_width-1:0]               w_snap;

  // Forwarding paths run regardless of mode; valids travel ungated with data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x  <= '0;
      r_xv <= '0;
      r_y  <= '0;
      r_yv <= 1'b0;
    end else begin
      r_x[0]  <= x_in;
      r_xv[0] <= x_val_in;
      for (int i = 1; i < x_delay; i++) begin
        r_x[i]  <= r_x[i-1];
        r_xv[i] <= r_xv[i-1];
      end
      r_y  <= y_in;
      r_yv <= y_val_in;
    end
  end

  assign w_pair     = r_xv[0] & r_yv;
  assign w_xe       = {{data_width{r_x[0][data_width-1]}}, r_x[0]};
  assign w_ye       = {{data_width{r_y[data_width-1]}}, r_y};
  assign w_prod     = w_xe * w_ye;
  assign w_prod_ext = acc_width'(w_prod);
  assign w_snap     = mode ? r_acc : '0;

  // Drain outranks clear so a combined drain+clear still snapshots the old tile.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
    end else if (!mode) begin
      r_acc <= '0;
    end else if (drain) begin
      r_acc <= w_pair ? w_prod_ext : '0;
    end else if (clear) begin
      r_acc <= '0;
    end else if (w_pair) begin
      r_acc <= r_acc + w_prod_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_ACC;
      r_cnt     <= '0;
      r_res     <= '0;
      r_res_val <= 1'b0;
    end else begin
      case (r_state)
        S_ACC: begin
          if (drain) begin
            r_res     <= w_snap;
            r_res_val <= 1'b1;
            r_cnt     <= N_UP;
            r_state   <= S_DRAIN;
          end else begin
            r_res_val <= 1'b0;
          end
        end
        default: begin
          if (drain) begin
            r_res     <= w_snap;
            r_res_val <= 1'b1;
            r_cnt     <= N_UP;
          end else if (r_cnt != '0) begin
            r_res     <= res_in;
            r_res_val <= res_val_in;
            r_cnt     <= r_cnt - 1'b1;
          end else begin
            r_res_val <= 1'b0;
            r_state   <= S_ACC;
          end
        end
      endcase
    end
  end

  assign x_out       = r_x[x_delay-1];
  assign x_val_out   = r_xv[x_delay-1];
  assign y_out       = r_y;
  assign y_val_out   = r_yv;
  assign res_out     = r_res;
  assign res_val_out = r_res_val;
  assign busy        = (r_state == S_DRAIN);

endmodule

// File: tb/tb_systolic_array_mac_pe.sv
// Self-checking bench for systolic_array_mac_pe: a single PE, a three-PE result
// chain and a narrow wrap-around PE, with drain results checked from a queue.
module tb_systolic_array_mac_pe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   total = 0;
  int   bad   = 0;
  logic [71:0] exp_q[$];
  logic [71:0] got_exp;

  // single PE, x_delay=3
  logic        m_mode, m_clear, m_drain, m_xv, m_yv, m_rvin;
  logic [31:0] m_x, m_y;
  logic [71:0] m_rin;
  logic [31:0] m_xo, m_yo;
  logic        m_xvo, m_yvo, m_rv, m_busy;
  logic [71:0] m_res;

  systolic_array_mac_pe #(.data_width(32), .acc_width(72), .x_delay(3), .n_upstream(0)) u_main (
    .clk(clk), .reset(reset), .mode(m_mode), .clear(m_clear), .drain(m_drain),
    .x_in(m_x), .x_val_in(m_xv), .y_in(m_y), .y_val_in(m_yv),
    .res_in(m_rin), .res_val_in(m_rvin),
    .x_out(m_xo), .x_val_out(m_xvo), .y_out(m_yo), .y_val_out(m_yvo),
    .res_out(m_res), .res_val_out(m_rv), .busy(m_busy));

  // chain: PE gi has n_upstream=gi; res chain index 0 is the tied-off far end
  logic              c_mode, c_clear, c_drain;
  logic [2:0][31:0]  c_x, c_y, c_xo, c_yo;
  logic [2:0]        c_xv, c_yv, c_xvo, c_yvo, c_busy;
  logic [3:0][71:0]  c_res;
  logic [3:0]        c_rv;
  assign c_res[0] = '0;
  assign c_rv[0]  = 1'b0;

  for (genvar gi = 0; gi < 3; gi++) begin : g_chain
    systolic_array_mac_pe #(.data_width(32), .acc_width(72), .x_delay(2), .n_upstream(gi)) u_pe (
      .clk(clk), .reset(reset), .mode(c_mode), .clear(c_clear), .drain(c_drain),
      .x_in(c_x[gi]), .x_val_in(c_xv[gi]), .y_in(c_y[gi]), .y_val_in(c_yv[gi]),
      .res_in(c_res[gi]), .res_val_in(c_rv[gi]),
      .x_out(c_xo[gi]), .x_val_out(c_xvo[gi]), .y_out(c_yo[gi]), .y_val_out(c_yvo[gi]),
      .res_out(c_res[gi+1]), .res_val_out(c_rv[gi+1]), .busy(c_busy[gi]));
  end

  // narrow PE for wrap-around
  logic        w_mode, w_clear, w_drain, w_xv, w_yv;
  logic [7:0]  w_x, w_y, w_xo, w_yo;
  logic        w_xvo, w_yvo, w_rv, w_busy;
  logic [15:0] w_res;
  logic [15:0] w_rin;
  logic        w_rvin;

  systolic_array_mac_pe #(.data_width(8), .acc_width(16), .x_delay(1), .n_upstream(0)) u_wrap (
    .clk(clk), .reset(reset), .mode(w_mode), .clear(w_clear), .drain(w_drain),
    .x_in(w_x), .x_val_in(w_xv), .y_in(w_y), .y_val_in(w_yv),
    .res_in(w_rin), .res_val_in(w_rvin),
    .x_out(w_xo), .x_val_out(w_xvo), .y_out(w_yo), .y_val_out(w_yvo),
    .res_out(w_res), .res_val_out(w_rv), .busy(w_busy));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chain_load(input int v2, input int v1, input int v0);
    c_mode  = 1'b1;
    c_clear = 1'b1;
    tick();
    c_clear = 1'b0;
    c_x[2] = v2; c_x[1] = v1; c_x[0] = v0;
    c_y    = {32'd1, 32'd1, 32'd1};
    c_xv   = 3'b111;
    c_yv   = 3'b111;
    tick();
    c_xv = 3'b000;
    c_yv = 3'b000;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    total++;
    if ({m_xo, m_xvo, m_yo, m_yvo, m_res, m_rv, m_busy} !== '0) begin
      bad++;
      $display("FAIL reset_main: got %h required 0", {m_xo, m_xvo, m_yo, m_yvo, m_res, m_rv, m_busy});
    end
    total++;
    if ({c_res[3], c_rv[3], c_busy[2], c_xo[2], c_yo[2]} !== '0) begin
      bad++;
      $display("FAIL reset_chain: got %h required 0", {c_res[3], c_rv[3], c_busy[2], c_xo[2], c_yo[2]});
    end
    total++;
    if ({w_res, w_rv, w_busy, w_xo, w_yo} !== '0) begin
      bad++;
      $display("FAIL reset_wrap: got %h required 0", {w_res, w_rv, w_busy, w_xo, w_yo});
    end
    $display("reset: outputs checked");
  endtask

  task automatic test_forward();
    m_mode = 1'b0;
    m_x = 32'h11; m_xv = 1'b1; m_y = 32'h22; m_yv = 1'b1;
    tick();
    m_x = '0; m_xv = 1'b0; m_y = '0; m_yv = 1'b0;
    total++;
    if ({m_yvo, m_yo} !== {1'b1, 32'h22}) begin
      bad++;
      $display("FAIL fwd_y_c1: got %b/%h required 1/00000022", m_yvo, m_yo);
    end
    total++;
    if (m_xvo !== 1'b0) begin
      bad++;
      $display("FAIL fwd_xval_c1: got %b required 0", m_xvo);
    end
    tick();
    total++;
    if ({m_xvo, m_yvo} !== 2'b00) begin
      bad++;
      $display("FAIL fwd_c2: got xv=%b yv=%b required 0 0", m_xvo, m_yvo);
    end
    tick();
    total++;
    if ({m_xvo, m_xo} !== {1'b1, 32'h11}) begin
      bad++;
      $display("FAIL fwd_x_c3: got %b/%h required 1/00000011", m_xvo, m_xo);
    end
    m_drain = 1'b1;
    exp_q.push_back(72'd0);
    tick();
    m_drain = 1'b0;
    got_exp = exp_q.pop_front();
    total++;
    if ({m_rv, m_res} !== {1'b1, got_exp}) begin
      bad++;
      $display("FAIL fwd_zero_drain: got %b/%h required 1/%h", m_rv, m_res, got_exp);
    end
    $display("forward: x/y latency and ZERO-mode drain checked");
    tick();
  endtask

  task automatic test_mac();
    int     pa[3] = '{3, -2, 7};
    int     pb[3] = '{4, 5, -1};
    longint s = 0;
    logic signed [71:0] e;
    m_mode  = 1'b1;
    m_clear = 1'b1;
    tick();
    m_clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_x = pa[i]; m_y = pb[i]; m_xv = 1'b1; m_yv = 1'b1;
      s += longint'(pa[i]) * longint'(pb[i]);
      tick();
    end
    m_xv = 1'b0; m_yv = 1'b0;
    tick();
    e = s;
    exp_q.push_back(e);
    m_drain = 1'b1;
    tick();
    m_drain = 1'b0;
    got_exp = exp_q.pop_front();
    total++;
    if ({m_rv, m_res} !== {1'b1, got_exp}) begin
      bad++;
      $display("FAIL mac_result: got %b/%h required 1/%h", m_rv, m_res, got_exp);
    end
    total++;
    if (m_busy !== 1'b1) begin
      bad++;
      $display("FAIL mac_busy: got %b required 1", m_busy);
    end
    tick();
    total++;
    if ({m_rv, m_busy} !== 2'b00) begin
      bad++;
      $display("FAIL mac_end: got rv=%b busy=%b required 0 0", m_rv, m_busy);
    end
    $display("mac: sum=%0d checked", s);
  endtask

  task automatic test_priority();
    m_clear = 1'b1;
    tick();
    m_clear = 1'b0;
    m_x = 32'd5; m_y = 32'd10; m_xv = 1'b1; m_yv = 1'b1;
    tick();
    m_x = 32'd2; m_y = 32'd3;
    tick();
    m_xv = 1'b0; m_yv = 1'b0;
    m_drain = 1'b1; m_clear = 1'b1;
    exp_q.push_back(72'd50);
    tick();
    m_drain = 1'b0; m_clear = 1'b0;
    got_exp = exp_q.pop_front();
    total++;
    if ({m_rv, m_res} !== {1'b1, got_exp}) begin
      bad++;
      $display("FAIL prio_drain_clear: got %b/%h required 1/%h", m_rv, m_res, got_exp);
    end
    tick();
    m_drain = 1'b1;
    exp_q.push_back(72'd6);
    tick();
    m_drain = 1'b0;
    got_exp = exp_q.pop_front();
    total++;
    if ({m_rv, m_res} !== {1'b1, got_exp}) begin
      bad++;
      $display("FAIL prio_new_tile: got %b/%h required 1/%h", m_rv, m_res, got_exp);
    end
    tick();
    m_x = 32'd2; m_y = 32'd3; m_xv = 1'b1; m_yv = 1'b1;
    tick();
    m_xv = 1'b0; m_yv = 1'b0; m_clear = 1'b1;
    tick();
    m_clear = 1'b0; m_drain = 1'b1;
    exp_q.push_back(72'd0);
    tick();
    m_drain = 1'b0;
    got_exp = exp_q.pop_front();
    total++;
    if ({m_rv, m_res} !== {1'b1, got_exp}) begin
      bad++;
      $display("FAIL prio_clear_drops: got %b/%h required 1/%h", m_rv, m_res, got_exp);
    end
    $display("priority: drain>clear>pair checked");
    tick();
  endtask

  task automatic test_back_to_back();
    m_clear = 1'b1;
    tick();
    m_clear = 1'b0;
    m_x = 32'd6; m_y = 32'd7; m_xv = 1'b1; m_yv = 1'b1;
    tick();
    m_x = 32'd4; m_y = 32'd4; m_drain = 1'b1;
    exp_q.push_back(72'd0);
    tick();
    m_xv = 1'b0; m_yv = 1'b0;
    got_exp = exp_q.pop_front();
    total++;
    if ({m_rv, m_res} !== {1'b1, got_exp}) begin
      bad++;
      $display("FAIL b2b_first: got %b/%h required 1/%h", m_rv, m_res, got_exp);
    end
    exp_q.push_back(72'd42);
    tick();
    m_drain = 1'b0;
    got_exp = exp_q.pop_front();
    total++;
    if ({m_rv, m_busy, m_res} !== {2'b11, got_exp}) begin
      bad++;
      $display("FAIL b2b_restart: got %b%b/%h required 11/%h", m_rv, m_busy, m_res, got_exp);
    end
    tick();
    total++;
    if ({m_rv, m_busy} !== 2'b00) begin
      bad++;
      $display("FAIL b2b_gap: got rv=%b busy=%b required 0 0", m_rv, m_busy);
    end
    m_drain = 1'b1;
    exp_q.push_back(72'd16);
    tick();
    m_drain = 1'b0;
    got_exp = exp_q.pop_front();
    total++;
    if ({m_rv, m_res} !== {1'b1, got_exp}) begin
      bad++;
      $display("FAIL b2b_third: got %b/%h required 1/%h", m_rv, m_res, got_exp);
    end
    $display("back_to_back: restart drains checked");
    tick();
  endtask

  task automatic test_chain();
    chain_load(10, 20, 30);
    c_drain = 1'b1;
    exp_q.push_back(72'd10);
    exp_q.push_back(72'd20);
    exp_q.push_back(72'd30);
    tick();
    c_drain = 1'b0;
    for (int k = 0; k < 3; k++) begin
      got_exp = exp_q.pop_front();
      total++;
      if ({c_rv[3], c_busy[2], c_res[3]} !== {2'b11, got_exp}) begin
        bad++;
        $display("FAIL chain_word%0d: got %b%b/%h required 11/%h", k, c_rv[3], c_busy[2], c_res[3], got_exp);
      end
      tick();
    end
    total++;
    if ({c_rv[3], c_busy[2]} !== 2'b00) begin
      bad++;
      $display("FAIL chain_end: got rv=%b busy=%b required 0 0", c_rv[3], c_busy[2]);
    end
    $display("chain: 3 results streamed");
  endtask

  task automatic test_reset_mid_drain();
    chain_load(1, 2, 3);
    c_drain = 1'b1;
    tick();
    c_drain = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if ({c_res[3], c_rv[3], c_busy[2], c_xvo[2], c_yvo[2]} !== '0) begin
      bad++;
      $display("FAIL rst_mid_drain: got %h/%b/%b required 0/0/0", c_res[3], c_rv[3], c_busy[2]);
    end
    tick();
    total++;
    if ({c_rv[3], c_busy[2]} !== 2'b00) begin
      bad++;
      $display("FAIL rst_abandon: got rv=%b busy=%b required 0 0", c_rv[3], c_busy[2]);
    end
    chain_load(7, 8, 9);
    c_drain = 1'b1;
    exp_q.push_back(72'd7);
    exp_q.push_back(72'd8);
    exp_q.push_back(72'd9);
    tick();
    c_drain = 1'b0;
    for (int k = 0; k < 3; k++) begin
      got_exp = exp_q.pop_front();
      total++;
      if ({c_rv[3], c_res[3]} !== {1'b1, got_exp}) begin
        bad++;
        $display("FAIL rst_redrain%0d: got %b/%h required 1/%h", k, c_rv[3], c_res[3], got_exp);
      end
      tick();
    end
    total++;
    if (c_busy[2] !== 1'b0) begin
      bad++;
      $display("FAIL rst_redrain_end: got busy=%b required 0", c_busy[2]);
    end
    $display("reset_mid_drain: abandon and re-drain checked");
  endtask

  task automatic test_wrap();
    logic [15:0] e;
    w_mode = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      w_clear = 1'b1;
      tick();
      w_clear = 1'b0;
      w_x = 8'h80; w_y = 8'h80; w_xv = 1'b1; w_yv = 1'b1;
      for (int i = 0; i < n; i++) tick();
      w_xv = 1'b0; w_yv = 1'b0;
      tick();
      e = 16'(n * 16384);
      exp_q.push_back(72'(e));
      w_drain = 1'b1;
      tick();
      w_drain = 1'b0;
      got_exp = exp_q.pop_front();
      total++;
      if ({w_rv, w_res} !== {1'b1, got_exp[15:0]}) begin
        bad++;
        $display("FAIL wrap_n%0d: got %b/%h required 1/%h", n, w_rv, w_res, got_exp[15:0]);
      end
      $display("wrap: %0d pairs -> %h", n, w_res);
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    m_mode = 1'b0; m_clear = 1'b0; m_drain = 1'b0;
    m_x = '0; m_y = '0; m_xv = 1'b0; m_yv = 1'b0;
    m_rin = 72'hDEAD_BEEF; m_rvin = 1'b1;
    c_mode = 1'b0; c_clear = 1'b0; c_drain = 1'b0;
    c_x = '0; c_y = '0; c_xv = '0; c_yv = '0;
    w_mode = 1'b0; w_clear = 1'b0; w_drain = 1'b0;
    w_x = '0; w_y = '0; w_xv = 1'b0; w_yv = 1'b0;
    w_rin = 16'h5A5A; w_rvin = 1'b1;
    test_reset();
    test_forward();
    test_mac();
    test_priority();
    test_back_to_back();
    test_chain();
    test_reset_mid_drain();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_array_mac_pe.md
# systolic_array_mac_pe

Parametrised output-stationary processing element for the systolic array. It forwards x and y operands with their valid bits to neighbouring PEs. In MAC mode it accumulates signed x·y products locally; in ZERO mode it acts as a pure skew/forwarding cell. On a broadcast drain it joins a per-column result shift chain, so finished accumulators stream out in order without bubbles.

## Interface
Parameters:
- data_width, 32, operand width (signed two's complement)
- acc_width, 72, accumulator/result width; must be ≥ 2·data_width
- x_delay, 2, x-path register stages (≥1); operand tap is stage 0, x_out is stage x_delay-1
- n_upstream, 0, number of PEs upstream on the result chain (results forwarded after own)

Ports:
- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high reset
- mode  in  1  0 = ZERO (forward only), 1 = MAC
- clear  in  1  zero accumulator
- drain  in  1  broadcast: snapshot accumulator and start result shift
- x_in / x_val_in  in  data_width / 1  x operand and valid
- y_in / y_val_in  in  data_width / 1  y operand and valid
- res_in / res_val_in  in  acc_width / 1  result chain from upstream PE
- x_out / x_val_out  out  data_width / 1  x after x_delay stages
- y_out / y_val_out  out  data_width / 1  y after 1 stage
- res_out / res_val_out  out  acc_width / 1  result chain toward array edge
- busy  out  1  high while in DRAIN

## Operation
- All registers, including every output, reset to 0; state resets to ACC and cnt resets to 0.
- Forwarding paths run in both modes. x/x_val shift through x_delay registers. y/y_val pass through one register. Valid bits travel with their data and are never gated.
- Operands are xq = x stage 0 and yq = the y register. The operands form a pair when x_val stage 0 and the y_val register are both 1.
- Product: xq·yq as a signed 2·data_width value, sign-extended to acc_width. The accumulator wraps modulo 2^acc_width, with no saturation.
- Accumulator update per edge, in priority order:
  1. mode=0 → acc ← 0.
  2. drain → acc ← product if pair, else 0. The new tile starts with the same-cycle product.
  3. clear → acc ← 0. Any same-cycle product is dropped.
  4. pair → acc ← acc + product.
  5. Otherwise hold.
- A drain with clear in the same cycle still snapshots the pre-clear acc.
- FSM (state, cnt of width max(1, clog2(n_upstream+1))):
  - ACC: res_val_out ← 0. On drain: res_out ← acc (0 in ZERO mode), res_val_out ← 1, cnt ← n_upstream, go to DRAIN.
  - DRAIN, drain=1: restart. Reload the snapshot from acc, cnt ← n_upstream.
  - DRAIN, cnt>0: res_out ← res_in, res_val_out ← res_val_in, cnt ← cnt-1.
  - DRAIN, cnt=0: res_val_out ← 0, go to ACC.
- res_in is ignored in ACC, so upstream garbage never appears on the chain.
- busy = (state == DRAIN).
- mode may change at any time. Switching to ZERO clears acc at the next edge. A ZERO-mode PE still drains a valid 0 so chain positions stay aligned.

## Timing
- x latency: x_delay cycles. y latency: 1 cycle.
- Product contribution: visible in acc 2 cycles after x_in/y_in if x_val_in and y_val_in are sampled on the same edge.
- Drain sampled at edge e0: own result valid in the cycle after e0. Upstream results follow on consecutive cycles, n_upstream of them. res_val_out is high for exactly n_upstream+1 cycles. busy is high for n_upstream+1 cycles, then falls.
- Chain-edge PE: tie res_in=0 and res_val_in=0.
- Reset asserted mid-drain: the next cycle has all outputs 0 and state ACC; the remaining drain is abandoned.

## Test plan
- Forwarding, x_delay=3: x_in=0x11 with val at cycle 0, y_in=0x22 → y_out=0x22 at cycle 1, x_out=0x11 at cycle 3, valids aligned; no acc change in mode=0.
- MAC: pairs (3,4), (-2,5), (7,-1) on consecutive cycles, then drain → res_out = 12-10-7 = -5 (sign-extended), res_val_out high for 1 cycle (n_upstream=0).
- Chain, n_upstream=2: three PEs preloaded with 10/20/30 (downstream→upstream), drain broadcast → edge PE emits 10, 20, 30 on consecutive cycles, then res_val_out=0, busy high 3 cycles.
- Priority: acc=50; drain+clear with pair (2,3) in the same cycle → res_out=50, acc=6 afterwards. clear alone with pair (2,3) → acc=0.
- Wrap: data_width=8, acc_width=16, repeated (-128)·(-128) pairs → acc wraps modulo 2^16 (16384, -32768, -16384, 0).
- Reset mid-drain (n_upstream=2, cycle 1 of drain): all outputs 0 next cycle, busy=0, a later drain behaves normally.
